pipeline_debug_controller: RTL
==============================

PIPELINE_DEBUG_CONTROLLER -- requirements
Module: pipeline_debug_controller

Interface
REQ-001 SHALL have parameter NB, default 32: datapath and dump word width.
REQ-002 SHALL have parameter NB_REGS, default 32: register-file entries dumped.
REQ-003 SHALL have parameter TAM_DATA_MEMORY, default 16: data-memory words dumped.
REQ-004 SHALL have parameter MAX_INSTR, default 64: instruction-memory capacity in words.
REQ-005 SHALL have the following ports (name, direction, width, meaning):
- i_clk  in  1  single clock; all state on rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_cmd  in  8  command byte.
- i_cmd_valid  in  1  command present.
- o_cmd_ready  out  1  command accepted this cycle.
- i_instr_word  in  NB  instruction to load.
- i_instr_valid  in  1  instruction word present.
- o_tx_data  out  NB  dump word.
- o_tx_valid  out  1  dump word valid.
- i_tx_ready  in  1  sink accepts dump word.
- o_step  out  1  pipeline advance enable.
- o_instruction_write_enable  out  1  instruction-memory write strobe.
- o_instruction_address  out  NB  byte address of the instruction write.
- o_debug_mips_register_number  out  5  register selected for readout.
- o_debug_address  out  NB  data-memory word address for readout.
- i_mips_pc  in  NB  current PC.
- i_mips_register_data  in  NB  selected register value.
- i_mips_data_memory  in  NB  selected memory word.
- i_mips_wb_halt  in  1  HALT reached writeback.
- o_halted  out  1  program finished.

Function
REQ-006 SHALL implement states IDLE, LOAD, RUN, STEP, DUMP.
REQ-007 SHALL, in IDLE, assert o_cmd_ready; a command SHALL be accepted when i_cmd_valid and o_cmd_ready are both high.
REQ-008 SHALL decode 0x4C ('L') -> LOAD, 0x43 ('C') -> RUN, 0x53 ('S') -> STEP, and 0x44 ('D') -> DUMP; any other byte is consumed with no effect.
REQ-009 SHALL ignore 'C' and 'S' while o_halted=1; 'L' clears o_halted.
REQ-010 SHALL, in LOAD, write each i_instr_valid word with o_instruction_write_enable pulsed for one cycle, address starting at 0 and incrementing by 4.
REQ-011 SHALL leave LOAD after writing word 0xFFFFFFFF (HALT, written) or after MAX_INSTR words, whichever comes first, then return to IDLE.
REQ-012 SHALL, in RUN, hold o_step=1 every cycle until i_wb_halt is sampled high, then drop o_step the next cycle, set o_halted, and enter DUMP.
REQ-013 SHALL, in STEP, assert o_step for exactly one cycle, then enter DUMP; if i_mips_wb_halt is high in that cycle, it SHALL set o_halted.
REQ-014 SHALL, in DUMP, emit in order: PC, registers 0..NB_REGS-1, data words 0..TAM_DATA_MEMORY-1, then return to IDLE.
REQ-015 SHALL drive each readout select, sample the input one cycle later, and hold o_tx_data and o_tx_valid stable until i_tx_ready is high.
REQ-016 SHALL drive o_debug_address as the word index multiplied by 4.
REQ-017 SHALL keep o_step=0 outside RUN and STEP, so the pipeline is frozen during DUMP and LOAD.
REQ-018 SHALL ignore i_cmd_valid outside IDLE, with o_cmd_ready held low.

Reset
REQ-019 SHALL, while i_reset=0, force state to IDLE and drive o_step, o_tx_valid, o_instruction_write_enable, and o_halted to 0, with all addresses, counters, and o_tx_data at 0.
REQ-020 SHALL, on reset mid-LOAD, RUN, or DUMP, abort immediately; no partial dump word SHALL remain valid after reset release.

Configuration
REQ-021 SHALL, with DEBUG_CYCLE_COUNT_EN defined, count o_step-high cycles since the last 'L' (32-bit, wrapping) and append the count as the final dump word.
REQ-022 SHALL, without DEBUG_CYCLE_COUNT_EN, contain no counter logic and make the dump exactly 1+NB_REGS+TAM_DATA_MEMORY words long.

Structure
REQ-023 SHALL take command codes, state encodings, and the HALT word from the shared header debug_constants.vh.
REQ-024 SHALL implement the readout sequencing and tx handshake in the sub-module dump_sequencer.

Verification
REQ-025 SHALL cover: 'L' followed by 3 words then 0xFFFFFFFF -> 4 write pulses at addresses 0, 4, 8, 12, then IDLE.
REQ-026 SHALL cover: 'S' after load -> o_step high for 1 cycle, then 49 dump words with first word = PC 4.
REQ-027 SHALL cover: 'C' on a 5-instruction program ending in HALT -> o_step drops the cycle after i_mips_wb_halt, o_halted=1, and a further 'S' produces no o_step.
REQ-028 SHALL cover: i_tx_ready held low 10 cycles during DUMP -> o_tx_data and o_tx_valid stay constant, and no word is lost or duplicated.
REQ-029 SHALL cover: i_reset pulsed low mid-DUMP -> o_tx_valid=0 immediately, then IDLE with o_cmd_ready=1 after release.
REQ-030 SHALL cover: with DEBUG_CYCLE_COUNT_EN, 3 single steps -> final word of the third dump = 3.

Source files
------------

// File: rtl/pipeline_debug_controller_pkg.sv
// Shared command codes, FSM encodings and the HALT instruction word for the
// pipeline debug controller and its dump sequencer.
package pipeline_debug_controller_pkg;

    localparam logic [7:0]  CMD_LOAD  = 8'h4C;  // 'L'
    localparam logic [7:0]  CMD_RUN   = 8'h43;  // 'C'
    localparam logic [7:0]  CMD_STEP  = 8'h53;  // 'S'
    localparam logic [7:0]  CMD_DUMP  = 8'h44;  // 'D'

    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_STEP,
        ST_DUMP
    } state_t;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_SETTLE,
        SEQ_HOLD
    } seq_phase_t;

endpackage

// File: rtl/pipeline_debug_controller_dump_sequencer.sv
// Walks PC, register file and data memory through the readout selects and
// streams each word over a valid/ready link. DEBUG_CYCLE_COUNT_EN appends the step count.
module dump_sequencer
    import pipeline_debug_controller_pkg::*;
#(
    parameter int NB              = 32,
    parameter int NB_REGS         = 32,
    parameter int TAM_DATA_MEMORY = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [NB-1:0] pc,
    input  logic [NB-1:0] reg_data,
    input  logic [NB-1:0] mem_data,
    input  logic          tx_ready,
`ifdef DEBUG_CYCLE_COUNT_EN
    input  logic [31:0]   cycle_count,
`endif
    output logic [NB-1:0] tx_data,
    output logic          tx_valid,
    output logic [4:0]    reg_num,
    output logic [NB-1:0] mem_addr,
    output logic          done
);

`ifdef DEBUG_CYCLE_COUNT_EN
    localparam int TOTAL = 2 + NB_REGS + TAM_DATA_MEMORY;
`else
    localparam int TOTAL = 1 + NB_REGS + TAM_DATA_MEMORY;
`endif
    localparam int            IW        = $clog2(TOTAL);
    localparam logic [IW-1:0] REG_LAST  = IW'(NB_REGS);
    localparam logic [IW-1:0] MEM_LAST  = IW'(NB_REGS + TAM_DATA_MEMORY);
    localparam logic [IW-1:0] WORD_LAST = IW'(TOTAL - 1);

    seq_phase_t    phase;
    logic [IW-1:0] idx;
    logic [NB-1:0] sample;

    // Selects decode straight from idx, so the source has a full cycle to settle
    // before SEQ_SETTLE captures it.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        sample   = '0;
        reg_num  = '0;
        mem_addr = '0;
        if (idx == '0) begin
            sample = pc;
        end else if (idx <= REG_LAST) begin
            reg_num = 5'(idx - IW'(1));
            sample  = reg_data;
        end else if (idx <= MEM_LAST) begin
            mem_addr = NB'({idx - REG_LAST - IW'(1), 2'b00});
            sample   = mem_data;
        end
`ifdef DEBUG_CYCLE_COUNT_EN
        else begin
            sample = NB'(cycle_count);
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase    <= SEQ_IDLE;
            idx      <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (phase)
                SEQ_IDLE: begin
                    if (start) begin
                        idx   <= '0;
                        phase <= SEQ_SETTLE;
                    end
                end
                SEQ_SETTLE: begin
                    tx_data  <= sample;
                    tx_valid <= 1'b1;
                    phase    <= SEQ_HOLD;
                end
                SEQ_HOLD: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        if (idx == WORD_LAST) begin
                            idx   <= '0;
                            done  <= 1'b1;
                            phase <= SEQ_IDLE;
                        end else begin
                            idx   <= idx + IW'(1);
                            phase <= SEQ_SETTLE;
                        end
                    end
                end
                default: phase <= SEQ_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/pipeline_debug_controller.sv
// Command-driven debug controller: loads instruction memory, runs or single-steps
// the pipeline, then dumps state. DEBUG_CYCLE_COUNT_EN adds a step counter to the dump.
module pipeline_debug_controller
    import pipeline_debug_controller_pkg::*;
#(
    parameter int NB              = 32,
    parameter int NB_REGS         = 32,
    parameter int TAM_DATA_MEMORY = 16,
    parameter int MAX_INSTR       = 64
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic [7:0]    i_cmd,
    input  logic          i_cmd_valid,
    output logic          o_cmd_ready,
    input  logic [NB-1:0] i_instr_word,
    input  logic          i_instr_valid,
    output logic [NB-1:0] o_tx_data,
    output logic          o_tx_valid,
    input  logic          i_tx_ready,
    output logic          o_step,
    output logic          o_instruction_write_enable,
    output logic [NB-1:0] o_instruction_address,
    output logic [4:0]    o_debug_mips_register_number,
    output logic [NB-1:0] o_debug_address,
    input  logic [NB-1:0] i_mips_pc,
    input  logic [NB-1:0] i_mips_register_data,
    input  logic [NB-1:0] i_mips_data_memory,
    input  logic          i_mips_wb_halt,
    output logic          o_halted
);

    localparam int            CW         = $clog2(MAX_INSTR + 1);
    localparam logic [CW-1:0] LAST_INSTR = CW'(MAX_INSTR - 1);

    state_t        state;
    logic          cmd_fire;
    logic          dump_start;
    logic          dump_done;
    logic [NB-1:0] load_addr;
    logic [CW-1:0] load_count;

    assign o_cmd_ready = (state == ST_IDLE);
    assign cmd_fire    = i_cmd_valid && o_cmd_ready;

    // The strobe and address accompany i_instr_word in the same cycle, since the
    // memory takes its write data straight from that input.
    assign o_instruction_write_enable = (state == ST_LOAD) && i_instr_valid;
    assign o_instruction_address      = load_addr;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state      <= ST_IDLE;
            o_step     <= 1'b0;
            o_halted   <= 1'b0;
            load_addr  <= '0;
            load_count <= '0;
            dump_start <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every branch reads pre-edge state.
            dump_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_fire) begin
                        case (i_cmd)
                            CMD_LOAD: begin
                                state      <= ST_LOAD;
                                o_halted   <= 1'b0;
                                load_addr  <= '0;
                                load_count <= '0;
                            end
                            CMD_RUN: begin
                                if (!o_halted) begin
                                    state  <= ST_RUN;
                                    o_step <= 1'b1;
                                end
                            end
                            CMD_STEP: begin
                                if (!o_halted) begin
                                    state  <= ST_STEP;
                                    o_step <= 1'b1;
                                end
                            end
                            CMD_DUMP: begin
                                state      <= ST_DUMP;
                                dump_start <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_LOAD: begin
                    if (i_instr_valid) begin
                        load_addr  <= load_addr + NB'(4);
                        load_count <= load_count + CW'(1);
                        if (i_instr_word == NB'(HALT_WORD) || load_count == LAST_INSTR)
                            state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (i_mips_wb_halt) begin
                        o_step     <= 1'b0;
                        o_halted   <= 1'b1;
                        state      <= ST_DUMP;
                        dump_start <= 1'b1;
                    end
                end
                ST_STEP: begin
                    o_step     <= 1'b0;
                    state      <= ST_DUMP;
                    dump_start <= 1'b1;
                    if (i_mips_wb_halt)
                        o_halted <= 1'b1;
                end
                ST_DUMP: begin
                    if (dump_done)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef DEBUG_CYCLE_COUNT_EN
    logic [31:0] cycle_count;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset)
            cycle_count <= '0;
        else if (cmd_fire && i_cmd == CMD_LOAD)
            cycle_count <= '0;
        else if (o_step)
            cycle_count <= cycle_count + 32'd1;
    end
`endif

    dump_sequencer #(
        .NB              (NB),
        .NB_REGS         (NB_REGS),
        .TAM_DATA_MEMORY (TAM_DATA_MEMORY)
    ) u_dump (
        .clk         (i_clk),
        .rst_n       (i_reset),
        .start       (dump_start),
        .pc          (i_mips_pc),
        .reg_data    (i_mips_register_data),
        .mem_data    (i_mips_data_memory),
        .tx_ready    (i_tx_ready),
`ifdef DEBUG_CYCLE_COUNT_EN
        .cycle_count (cycle_count),
`endif
        .tx_data     (o_tx_data),
        .tx_valid    (o_tx_valid),
        .reg_num     (o_debug_mips_register_number),
        .mem_addr    (o_debug_address),
        .done        (dump_done)
    );

endmodule
